// File: rtl/spi_slave_ram_param.sv
// rtl/spi_slave_ram_param.sv - SPI slave with parametrised single-port RAM; optional burst streaming via SPI_BURST_EN
//
// Frame layout (SS_n low): one select edge, two command bits (MSB first), then payload.
//   cmd 00: set write address     cmd 01: write data word
//   cmd 10: set read address      cmd 11: read data word (shifted out on MISO)
// SPI_BURST_EN: data frames keep streaming consecutive words with address auto-increment.
module spi_slave_ram_param #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO
);

  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam int MAXW       = (DATA_WIDTH > ADDR_WIDTH) ? DATA_WIDTH : ADDR_WIDTH;
  localparam int CW         = $clog2(MAXW + 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] CHK_CMD = 3'd1;
  localparam logic [2:0] CMD_LSB = 3'd2;
  localparam logic [2:0] WR_ADDR = 3'd3;
  localparam logic [2:0] WR_DATA = 3'd4;
  localparam logic [2:0] RD_ADDR = 3'd5;
  localparam logic [2:0] RD_DATA = 3'd6;
  localparam logic [2:0] DONE    = 3'd7;

  // Counter values marking the last payload bit and the end of a read word
  localparam logic [CW-1:0]         ADDR_LAST = CW'(ADDR_WIDTH - 1);
  localparam logic [CW-1:0]         DATA_LAST = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0]         DATA_END  = CW'(DATA_WIDTH);
  // One extra bit so DEPTH itself is representable for the range compare
  localparam logic [ADDR_WIDTH:0]   DEPTH_X   = (ADDR_WIDTH + 1)'(DEPTH);

  logic [2:0]            state;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [CW-1:0]         cnt;
  logic [MAXW-2:0]       shift;
  logic [DATA_WIDTH-1:0] tx;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [MAXW-1:0]       word_in;
  logic [ADDR_WIDTH-1:0] addr_in;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  wr_ok;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] fetch_addr;
  logic [DATA_WIDTH-1:0] fetch_word;

`ifdef SPI_BURST_EN
  localparam logic [ADDR_WIDTH-1:0] ADDR_TOP = ADDR_WIDTH'(DEPTH - 1);
  logic [ADDR_WIDTH-1:0] wr_next;
  logic [ADDR_WIDTH-1:0] rd_next;

  // Successor addresses for streaming; the top of the RAM wraps to zero
  always_comb begin
    wr_next = (wr_addr == ADDR_TOP) ? '0 : wr_addr + 1'b1;
    rd_next = (rd_addr == ADDR_TOP) ? '0 : rd_addr + 1'b1;
  end
`endif

  // Payload assembly: the bit on MOSI now completes the word held in shift
  always_comb begin
    word_in = {shift, MOSI};
    addr_in = word_in[ADDR_WIDTH-1:0];
    data_in = word_in[DATA_WIDTH-1:0];
    wr_ok   = {1'b0, wr_addr} < DEPTH_X;
    mem_we  = (state == WR_DATA) && !SS_n && (cnt == DATA_LAST) && wr_ok;
  end

  // Read fetch: first word from rd_addr, later burst words prefetched from the successor
  always_comb begin
`ifdef SPI_BURST_EN
    fetch_addr = (cnt == '0) ? rd_addr : rd_next;
`else
    fetch_addr = rd_addr;
`endif
    fetch_word = ({1'b0, fetch_addr} < DEPTH_X) ? mem[fetch_addr] : '0;
  end

  // Serial output is driven only while a word is being presented
  always_comb begin
    MISO = (state == RD_DATA) && tx[DATA_WIDTH-1];
  end

  // RAM write port; out-of-range writes are suppressed by mem_we
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_addr] <= data_in;
    end
  end

  // Frame sequencer: command decode, payload capture, read shifting, abort on SS_n high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      wr_addr <= '0;
      rd_addr <= '0;
      cnt     <= '0;
      shift   <= '0;
      tx      <= '0;
    end else if (SS_n) begin
      state <= IDLE;
      cnt   <= '0;
      shift <= '0;
      tx    <= '0;
    end else begin
      case (state)
        IDLE: begin
          state <= CHK_CMD;
          cnt   <= '0;
        end
        CHK_CMD: begin
          shift <= word_in[MAXW-2:0];
          state <= CMD_LSB;
        end
        CMD_LSB: begin
          cnt <= '0;
          case ({shift[0], MOSI})
            2'b00: state <= WR_ADDR;
            2'b01: state <= WR_DATA;
            2'b10: state <= RD_ADDR;
            2'b11: state <= RD_DATA;
          endcase
        end
        WR_ADDR: begin
          shift <= word_in[MAXW-2:0];
          if (cnt == ADDR_LAST) begin
            wr_addr <= addr_in;
            cnt     <= '0;
            state   <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WR_DATA: begin
          shift <= word_in[MAXW-2:0];
          if (cnt == DATA_LAST) begin
            cnt <= '0;
`ifdef SPI_BURST_EN
            wr_addr <= wr_next;
`else
            state <= DONE;
`endif
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RD_ADDR: begin
          shift <= word_in[MAXW-2:0];
          if (cnt == ADDR_LAST) begin
            rd_addr <= addr_in;
            cnt     <= '0;
            state   <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RD_DATA: begin
          if (cnt == '0) begin
            tx  <= fetch_word;
            cnt <= CW'(1);
          end else if (cnt == DATA_END) begin
`ifdef SPI_BURST_EN
            tx      <= fetch_word;
            rd_addr <= rd_next;
            cnt     <= CW'(1);
`else
            tx    <= '0;
            cnt   <= '0;
            state <= DONE;
`endif
          end else begin
            tx  <= {tx[DATA_WIDTH-2:0], 1'b0};
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_ram_param.sv
// tb/tb_spi_slave_ram_param.sv - randomized model-checked bench for spi_slave_ram_param (DEPTH 256 and 200)
module tb_spi_slave_ram_param;

`ifdef SPI_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic SS_n;
  logic MOSI;
  logic miso0;
  logic miso1;

  always #5 clk = ~clk;

  spi_slave_ram_param dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .SS_n  (SS_n),
    .MOSI  (MOSI),
    .MISO  (miso0)
  );

  spi_slave_ram_param #(.DATA_WIDTH(8), .DEPTH(200)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .SS_n  (SS_n),
    .MOSI  (MOSI),
    .MISO  (miso1)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: per-instance RAM image and address registers
  logic [7:0]  mem [2][256];
  int          wr [2];
  int          rd [2];
  int          dep [2] = '{256, 200};
  logic        exp_m [2] = '{1'b0, 1'b0};
  logic        mseq [0:127];
  logic [31:0] cap [2];

  function automatic int inc_a(int d, int a);
    if (a == dep[d] - 1) return 0;
    return (a + 1) % 256;
  endfunction

  function automatic logic [7:0] word_at(int d, int a);
    if (a < dep[d]) return mem[d][a];
    return 8'h00;
  endfunction

  // Bit presented after edge E(k) of a read frame that began at address a0
  function automatic logic read_bit(int d, int a0, int k);
    int a;
    int m;
    int b;
    logic [7:0] w;
    a = a0;
    if (BURST) begin
      m = (k - 2) / 8;
      b = (k - 2) % 8;
      for (int i = 0; i < m; i++) a = inc_a(d, a);
    end else begin
      if (k > 9) return 1'b0;
      b = k - 2;
    end
    w = word_at(d, a);
    return w[7 - b];
  endfunction

  function automatic int pay(int start);
    int v;
    v = 0;
    for (int i = 0; i < 8; i++) v = (v << 1) | (mseq[start + i] ? 1 : 0);
    return v;
  endfunction

  task automatic model_reset();
    wr[0] = 0; wr[1] = 0;
    rd[0] = 0; rd[1] = 0;
    exp_m[0] = 1'b0; exp_m[1] = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  // Cycle-by-cycle output comparison against the model
  always @(posedge clk) begin
    #3;
    checks += 2;
    if (miso0 !== exp_m[0]) begin
      errors++;
      $display("FAIL miso_d256 t=%0t got %b want %b", $time, miso0, exp_m[0]);
    end
    if (miso1 !== exp_m[1]) begin
      errors++;
      $display("FAIL miso_d200 t=%0t got %b want %b", $time, miso1, exp_m[1]);
    end
  end

  // One frame: L edges with SS_n low, optional reset pulse after low edge rst_at
  task automatic frame(input logic [1:0] cmd, input logic [63:0] bits, input int nbits,
                       input int L, input int ncap, input int rst_at);
    int rd0 [2];
    int k;
    int p;
    int c;
    int v;
    bit was_rst;
    was_rst = 1'b0;
    rd0[0] = rd[0];
    rd0[1] = rd[1];
    cap[0] = '0;
    cap[1] = '0;
    for (int j = 0; j < L; j++) begin
      @(negedge clk);
      SS_n = 1'b0;
      if (j == 1) MOSI = cmd[1];
      else if (j == 2) MOSI = cmd[0];
      else if (j >= 3 && (j - 3) < nbits) MOSI = bits[nbits - 1 - (j - 3)];
      else MOSI = 1'($urandom);
      mseq[j] = MOSI;
      @(posedge clk);
      #1;
      k = j - 1;
      for (int d = 0; d < 2; d++)
        exp_m[d] = (cmd == 2'b11 && k >= 2) ? read_bit(d, rd0[d], k) : 1'b0;
      #1;
      if (cmd == 2'b11 && k >= 2 && (k - 2) < ncap) begin
        cap[0] = {cap[0][30:0], miso0};
        cap[1] = {cap[1][30:0], miso1};
      end
      if (j == rst_at) begin
        #2;
        SS_n = 1'b1;
        rst_n = 1'b0;
        model_reset();
        #1;
        rst_n = 1'b1;
        was_rst = 1'b1;
        break;
      end
    end
    @(negedge clk);
    SS_n = 1'b1;
    MOSI = 1'($urandom);
    @(posedge clk);
    #1;
    exp_m[0] = 1'b0;
    exp_m[1] = 1'b0;
    repeat ($urandom_range(0, 2)) @(posedge clk);
    if (!was_rst && L >= 3) begin
      p = L - 3;
      case (cmd)
        2'b00: if (p >= 8) for (int d = 0; d < 2; d++) wr[d] = pay(3);
        2'b01: begin
          c = BURST ? p / 8 : ((p >= 8) ? 1 : 0);
          for (int w = 0; w < c; w++) begin
            v = pay(3 + 8 * w);
            for (int d = 0; d < 2; d++) begin
              if (wr[d] < dep[d]) mem[d][wr[d]] = v[7:0];
              if (BURST) wr[d] = inc_a(d, wr[d]);
            end
          end
        end
        2'b10: if (p >= 8) for (int d = 0; d < 2; d++) rd[d] = pay(3);
        default: begin
          if (BURST && L >= 4) begin
            c = (L - 4) / 8;
            for (int d = 0; d < 2; d++)
              for (int i = 0; i < c; i++) rd[d] = inc_a(d, rd[d]);
          end
        end
      endcase
    end
  endtask

  task automatic write_at(input int a, input int v);
    frame(2'b00, 64'(a), 8, 11, 0, -1);
    frame(2'b01, 64'(v), 8, 11, 0, -1);
  endtask

  task automatic read_at(input int a, input int ncap);
    frame(2'b10, 64'(a), 8, 11, 0, -1);
    frame(2'b11, 64'd0, 0, 4 + ncap, ncap, -1);
  endtask

  initial begin
    rst_n = 1'b0;
    SS_n  = 1'b1;
    MOSI  = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    check("reset_miso_d256", {31'd0, miso0}, 32'd0);
    check("reset_miso_d200", {31'd0, miso1}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int a = 0; a < 256; a++) write_at(a, int'($urandom_range(0, 255)));

    write_at(8'h3C, 8'hA5);
    check("model_ram_3c", {24'd0, mem[0][8'h3C]}, 32'hA5);
    read_at(8'h3C, 8);
    check("read_a5_d256", cap[0], 32'hA5);
    check("read_a5_d200", cap[1], 32'hA5);

    frame(2'b01, 64'hFF, 8, 8, 0, -1);
    read_at(8'h3C, 8);
    check("abort_keep_d256", cap[0], 32'hA5);
    check("abort_keep_d200", cap[1], 32'hA5);

    write_at(8'h00, 8'h5A);
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    rst_n = 1'b1;
    frame(2'b11, 64'd0, 0, 12, 8, -1);
    check("noaddr_read_d256", cap[0], 32'h5A);
    check("noaddr_read_d200", cap[1], 32'h5A);

    write_at(8'hF0, 8'h77);
    read_at(8'hF0, 8);
    check("addr_f0_d256", cap[0], 32'h77);
    check("range_f0_d200", cap[1], 32'h00);
    write_at(199, 8'hC3);
    read_at(199, 8);
    check("addr_199_d256", cap[0], 32'hC3);
    check("addr_199_d200", cap[1], 32'hC3);

    write_at(8'h10, 8'h99);
    frame(2'b00, 64'h10, 8, 11, 0, -1);
    frame(2'b01, 64'h66, 8, 11, 0, 5);
    check("rst_wr_addr_model", 32'(wr[0]), 32'd0);
    read_at(8'h10, 8);
    check("rst_ram_kept_d256", cap[0], 32'h99);
    check("rst_ram_kept_d200", cap[1], 32'h99);
    frame(2'b01, 64'h42, 8, 11, 0, -1);
    read_at(8'h00, 8);
    check("rst_wr_zero_d256", cap[0], 32'h42);
    check("rst_wr_zero_d200", cap[1], 32'h42);

`ifdef SPI_BURST_EN
    frame(2'b00, 64'hFE, 8, 11, 0, -1);
    frame(2'b01, 64'h112233, 24, 27, 0, -1);
    check("burst_model_fe", {24'd0, mem[0][8'hFE]}, 32'h11);
    check("burst_model_ff", {24'd0, mem[0][8'hFF]}, 32'h22);
    check("burst_model_00", {24'd0, mem[0][8'h00]}, 32'h33);
    frame(2'b10, 64'hFE, 8, 11, 0, -1);
    frame(2'b11, 64'd0, 0, 27, 24, -1);
    check("burst_read_d256", cap[0], 32'h112233);
    check("burst_read_d200", cap[1], 32'h000033);
`endif

    for (int n = 0; n < 250; n++) begin
      logic [1:0] cmd;
      int L;
      int ra;
      cmd = 2'($urandom_range(0, 3));
      L = $urandom_range(1, BURST ? 30 : 14);
      ra = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, L - 1)) : -1;
      frame(cmd, {$urandom, $urandom}, 64, L, 0, ra);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    errors++;
    $display("FAIL watchdog timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_slave_ram_param.md
Name: spi_slave_ram_param

Overview:
- Parametrised successor to the fixed 8-bit SPI slave with integrated single-port RAM.
- Generalises data width and memory depth.
- Replaces the implicit read-address-pending flag with explicit 2-bit command decoding and separate write/read address registers.
- Adds clean frame abort and address range checking; the optional burst mode adds auto-increment streaming.
- Sits between an external SPI master (mode-0 style, sampled on clk rising edge) and on-chip storage.

Parameters:
- DATA_WIDTH, 8, RAM word width and data payload bits per frame (>=2).
- DEPTH, 256, number of RAM words (>=2, need not be a power of two).
- ADDR_WIDTH, $clog2(DEPTH), address payload bits per frame (derived localparam, not overridable).

Ports:
- clk  input  1  system clock; all sampling on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- SS_n  input  1  slave select, active low; frame is valid while low.
- MOSI  input  1  serial data in, MSB first.
- MISO  output  1  serial data out, MSB first; 0 when not transmitting.

Behaviour:
- Reset (async, rst_n=0): state IDLE, MISO=0, wr_addr=0, rd_addr=0, bit counter=0, shift/tx registers=0. RAM contents are not reset.
- States: IDLE, CHK_CMD, CMD_LSB, WR_ADDR, WR_DATA, RD_ADDR, RD_DATA, DONE.
- IDLE: SS_n=0 at an edge -> CHK_CMD.
- CHK_CMD, edge E0: samples cmd[1]; next state CMD_LSB.
- CMD_LSB, edge E1: samples cmd[0].
  - cmd 00 -> WR_ADDR.
  - cmd 01 -> WR_DATA.
  - cmd 10 -> RD_ADDR.
  - cmd 11 -> RD_DATA.
- Payload frames (WR_ADDR, WR_DATA, RD_ADDR): payload length N = ADDR_WIDTH for address commands, DATA_WIDTH for data.
  - Payload bits are sampled at E2..E(1+N), MSB first.
  - At E(1+N) the action uses {shift[N-2:0], MOSI}, then state -> DONE.
- Actions at E(1+N):
  - WR_ADDR: wr_addr <= payload.
  - WR_DATA: RAM[wr_addr] <= payload.
  - RD_ADDR: rd_addr <= payload.
- RD_DATA: no payload.
  - tx register loads RAM[rd_addr] at E2.
  - MISO = word MSB during the cycle after E2.
  - tx shifts left at E3..E(1+DW), DW = DATA_WIDTH, so exactly DW bits are presented, one per cycle.
  - At E(2+DW): MISO=0, state -> DONE.
  - MOSI is ignored in RD_DATA.
- DONE: MOSI ignored, MISO=0. SS_n=1 -> IDLE.
- Abort: SS_n=1 at any edge in a non-IDLE state -> IDLE at that edge.
  - No RAM write and no address update for the partial frame.
  - MISO=0 from that edge on; counter cleared.
- Range: an address >= DEPTH is stored as given.
  - A write to such an address is dropped.
  - A read from such an address returns all zeros.
- A read with no prior RD_ADDR frame uses rd_addr=0.
- Back-to-back frames: at least one cycle with SS_n=1 between frames.
- Reset asserted mid-frame: immediate return to the reset values; the frame is lost.

Optional Feature:
- Macro SPI_BURST_EN.
- Defined:
  - WR_DATA does not go to DONE after a word. Each further group of DW bits, while SS_n stays low, writes RAM[wr_addr+k] with no gap cycles. wr_addr increments after each completed write and wraps DEPTH-1 -> 0.
  - RD_DATA streams consecutive words RAM[rd_addr], RAM[rd_addr+1], ... contiguously on MISO. There is no idle bit between words; prefetch is required. rd_addr increments after each completed word, with the same wrap rule.
  - A partial trailing group at abort is discarded.
  - Addresses hold their incremented values after the frame.
- Undefined:
  - Single-word frames as described in Behaviour.
  - wr_addr and rd_addr never auto-increment.

Test Plan:
- Reset, then cmd 00 with addr 0x3C, then cmd 01 with data 0xA5, then cmd 10 with addr 0x3C, then cmd 11 -> MISO shifts 1,0,1,0,0,1,0,1 in cycles E2..E9; MISO=0 otherwise.
- Abort: cmd 01 with 0xFF, SS_n raised after 5 payload bits -> RAM[0x3C] still reads back 0xA5.
- Read with no prior RD_ADDR after reset (RAM[0] preloaded 0x5A) -> MISO serialises 0x5A.
- DEPTH=200: write 0x77 to address 0xF0 then read it back -> MISO all zeros; a write to address 199 reads back correctly.
- Reset mid-WR_DATA (rst_n low for 1 ns after 3 payload bits) -> state IDLE, MISO=0, wr_addr=0, RAM unchanged.
- SPI_BURST_EN, DEPTH=256: wr_addr=0xFE, one WR_DATA frame carrying 0x11, 0x22, 0x33 -> RAM[0xFE]=0x11, RAM[0xFF]=0x22, RAM[0x00]=0x33. A burst read from rd_addr=0xFE -> 24 contiguous MISO bits 0x112233.
